mlp_mul_rr_arbiter: RTL
=======================

// Module: mlp_mul_rr_arbiter
// PURPOSE
//  Shares one pipelined 14-bit signed MLP multiplier between NUM_REQ requesters (neuron/layer engines).
//  Round-robin arbitration issues at most one operand pair per cycle.
//  Each issue is tagged with its requester ID; the tag travels in a shift pipe matched to the multiplier latency.
//  The product is returned with the tag; the block drives the multiplier ce and supports a global hold/stall.
// PARAMETERS
//  NUM_REQ      4   number of requesters, >=2; ID_W = $clog2(NUM_REQ) (localparam)
//  DATA_W       14  operand/product width, signed two's complement
//  MUL_LATENCY  3   ce-enabled edges from mul_din sampled to valid mul_dout (>=1)
// PORTS
//  clk        in   1               clock, all logic rising-edge
//  reset_n    in   1               asynchronous, active-low reset
//  hold       in   1               1 = freeze multiplier and tag pipe, no new grants
//  req_valid  in   NUM_REQ         request i valid; operands held stable until req_ready[i]
//  req_ready  out  NUM_REQ         one-hot grant; transfer when valid&ready
//  req_a      in   NUM_REQ*DATA_W  operand A, requester i in bits [i*DATA_W +: DATA_W]
//  req_b      in   NUM_REQ*DATA_W  operand B, same packing
//  rsp_valid  out  NUM_REQ         one-hot: product for requester i on rsp_data this cycle
//  rsp_data   out  DATA_W          product (low DATA_W bits of a*b, wraps)
//  rsp_id     out  ID_W            requester index of rsp_data
//  mul_ce     out  1               multiplier clock enable
//  mul_din0   out  DATA_W          multiplier operand 0
//  mul_din1   out  DATA_W          multiplier operand 1
//  mul_dout   in   DATA_W          multiplier product
//  cnt_clr    in   1               clear issue counter (MLP_MUL_ARB_PERF_EN only)
//  issue_cnt  out  32              issued-operation count (MLP_MUL_ARB_PERF_EN only)
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, rsp_id=0, issue_cnt=0, rr pointer=NUM_REQ-1 (req 0 wins first), tag pipe valid bits=0.
//  mul_ce = ~hold (combinational). Multiplier is not reset; in-flight data is discarded via the tag pipe.
//  Arbitration (combinational, hold=0): scan from ptr+1 modulo NUM_REQ; first i with req_valid[i] gets req_ready[i]=1.
//    All others 0. No grant when hold=1 or no valid request.
//  req_ready depends on req_valid; requesters must not make valid depend on ready.
//  Issue cycle t: mul_din0/1 = granted req_a/req_b.
//    Edge t: ptr<=granted index; tag {1,id} enters tag pipe stage 0.
//  No grant: mul_din0/1 = 0; tag valid 0 enters the pipe (bubble). ptr unchanged.
//  Tag pipe: MUL_LATENCY stages; shifts only when mul_ce=1.
//    Result for issue at t appears at cycle t+MUL_LATENCY (no hold in between):
//    rsp_valid[id]=1, rsp_id=id, rsp_data=mul_dout.
//  Each hold cycle delays in-flight responses by one cycle.
//  hold=1: rsp_valid forced 0, pipe frozen; outputs resume exactly where stopped on release.
//  Throughput 1 op/cycle. Sustained all-valid traffic gives grants 0,1,..,NUM_REQ-1,0,...
//  A single requester valid every cycle is granted every cycle.
//  No backpressure on responses; consumers must accept rsp_valid unconditionally.
//  rsp_id/rsp_data when rsp_valid=0: rsp_id holds last value; rsp_data = mul_dout (don't care).
//  reset_n low mid-operation: in-flight tags dropped immediately.
//    No rsp_valid after reset release until new issues complete the latency.
// CONFIGURATION
//  `MLP_MUL_ARB_PERF_EN defined:
//    issue_cnt increments on every grant cycle; saturates at 32'hFFFFFFFF.
//    cnt_clr=1 synchronously sets it to 0; clear wins over a same-cycle grant.
//  Not defined: issue_cnt tied to 0, cnt_clr ignored, no counter flops.
// TESTING
//  1 Single issue: req_valid[2], a=3, b=-5, hold=0 -> req_ready[2] same cycle.
//    3 cycles later rsp_valid=4'b0100, rsp_id=2, rsp_data=-15.
//  2 All 4 valid for 8 cycles -> grants 0,1,2,3,0,1,2,3.
//    Responses in same order, each 3 cycles after its grant, one per cycle.
//  3 Wrap: a=b=200 -> rsp_data = 40000 mod 2^14 = 7232 (signed: 7232).
//    a=-8192, b=-1 -> rsp_data=-8192.
//  4 Hold: issue at t, hold=1 on cycles t+1..t+2 -> mul_ce=0 and no grants during hold.
//    Response at t+5, not t+3; no duplicate rsp_valid.
//  5 Reset mid-flight: 3 ops issued, reset_n low 1 cycle before first response.
//    No rsp_valid after release; ptr reset so req 0 wins next.
//  6 PERF_EN: 10 grants -> issue_cnt=10; cnt_clr with grant same cycle -> 0.
//    Without macro issue_cnt stays 0.

Source files
------------

// File: rtl/mlp_mul_rr_arbiter.sv
// mlp_mul_rr_arbiter: round-robin sharing of one pipelined multiplier with a tagged return path.
// Define MLP_MUL_ARB_PERF_EN to add the saturating issue counter (issue_cnt/cnt_clr).
module mlp_mul_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 14,
  parameter int MUL_LATENCY = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        hold,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic                        mul_ce,
  output logic [DATA_W-1:0]           mul_din0,
  output logic [DATA_W-1:0]           mul_din1,
  input  logic [DATA_W-1:0]           mul_dout,
  input  logic                        cnt_clr,
  output logic [31:0]                 issue_cnt
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [ID_W-1:0] ptr, gnt_id, cand, rsp_id_q;
  logic gnt, rsp_fire;
  logic tv [MUL_LATENCY];
  logic [ID_W-1:0] tid [MUL_LATENCY];
  // descending scan so the candidate nearest ptr+1 is written last and wins
  always_comb begin
    gnt = 1'b0;
    gnt_id = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        gnt = 1'b1;
        gnt_id = cand;
      end
    end
    gnt = gnt & ~hold & reset_n;
  end
  assign mul_ce    = ~hold;
  assign req_ready = gnt ? (NUM_REQ'(1) << gnt_id) : '0;
  assign mul_din0  = gnt ? req_a[int'(gnt_id)*DATA_W +: DATA_W] : '0;
  assign mul_din1  = gnt ? req_b[int'(gnt_id)*DATA_W +: DATA_W] : '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= ID_W'(NUM_REQ - 1);
      rsp_id_q <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tv[i] <= 1'b0;
        tid[i] <= '0;
      end
    end else begin
      ptr <= gnt ? gnt_id : ptr;
      rsp_id_q <= rsp_id;
      if (!hold) begin
        tv[0] <= gnt;
        tid[0] <= gnt_id;
        for (int i = 1; i < MUL_LATENCY; i++) begin
          tv[i] <= tv[i-1];
          tid[i] <= tid[i-1];
        end
      end
    end
  end
  // tag pipe freezes with the multiplier, so the last stage always lines up with mul_dout
  assign rsp_fire  = tv[MUL_LATENCY-1] & ~hold;
  assign rsp_valid = rsp_fire ? (NUM_REQ'(1) << tid[MUL_LATENCY-1]) : '0;
  assign rsp_id    = rsp_fire ? tid[MUL_LATENCY-1] : rsp_id_q;
  assign rsp_data  = mul_dout;
`ifdef MLP_MUL_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) issue_cnt <= '0;
    else if (cnt_clr) issue_cnt <= '0;
    else if (gnt && issue_cnt != '1) issue_cnt <= issue_cnt + 32'd1;
  end
`else
  logic unused_clr;
  assign unused_clr = cnt_clr;
  assign issue_cnt = '0;
`endif
endmodule
